// File: rtl/vpipe_issue_if.sv
// Producer-side valid/ready bus carrying {op, operand1, operand2} into the
// vpipe issue queue. The producer uses the master modport and the queue uses slave.
interface vpipe_issue_if #(
  parameter int OPW = 2,
  parameter int RW  = 3
);
  logic           in_valid;
  logic           in_ready;
  logic [OPW-1:0] in_op;
  logic [RW-1:0]  in_operand1;
  logic [RW-1:0]  in_operand2;

  modport master (
    output in_valid,
    output in_op,
    output in_operand1,
    output in_operand2,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_op,
    input  in_operand1,
    input  in_operand2,
    output in_ready
  );
endinterface

// File: rtl/vpipe_issue_queue.sv
// DEPTH-entry issue FIFO feeding the vpipe processor one instruction or bubble per cycle.
// Optional operand range clamping is enabled with the macro VPIPE_ISSUE_CLAMP_EN.
module vpipe_issue_queue #(
  parameter int DEPTH      = 4,
  parameter int RF_ENTRIES = 6,
  parameter int OPW        = 2,
  parameter int RW         = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  vpipe_issue_if.slave           in_if,
  input  logic                   stall,
  output logic [OPW-1:0]         out_op,
  output logic [RW-1:0]          out_operand1,
  output logic [RW-1:0]          out_operand2,
  output logic                   out_issue,
  output logic                   out_is_load,
  output logic [$clog2(DEPTH):0] count,
  output logic [7:0]             issued_cnt,
  output logic                   clamp_err
);
  localparam int             PW        = $clog2(DEPTH);
  localparam logic [OPW-1:0] OP_BUBBLE = '1;
  localparam logic [OPW-1:0] OP_LOAD   = OPW'(2);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("vpipe_issue_queue: DEPTH must be a power of 2 and >= 2");
  end
  if (RF_ENTRIES < 1 || RF_ENTRIES > (1 << RW)) begin : g_bad_rf
    $error("vpipe_issue_queue: RF_ENTRIES must lie in 1..2**RW");
  end

  typedef struct packed {
    logic [OPW-1:0] op;
    logic [RW-1:0]  operand1;
    logic [RW-1:0]  operand2;
  } entry_t;

  entry_t          r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [PW:0]     r_count;
  logic [OPW-1:0]  r_out_op;
  logic [RW-1:0]   r_out_operand1;
  logic [RW-1:0]   r_out_operand2;
  logic            r_out_issue;
  logic            r_out_is_load;
  logic [7:0]      r_issued_cnt;
  logic            r_clamp_err;

  entry_t          w_head;
  logic            w_push;
  logic            w_pop;
  logic [RW-1:0]   w_op1;
  logic [RW-1:0]   w_op2;
  logic            w_clamp;

  assign in_if.in_ready = (r_count < (PW + 1)'(DEPTH));
  assign w_push         = in_if.in_valid && in_if.in_ready;
  assign w_pop          = !stall && (r_count != '0);
  assign w_head         = r_mem[r_rd_ptr];

`ifdef VPIPE_ISSUE_CLAMP_EN
  // Out-of-range register indices are forced to r0, matching the ILA model.
  logic w_bad1;
  logic w_bad2;
  assign w_bad1  = 32'(w_head.operand1) > 32'(RF_ENTRIES - 1);
  assign w_bad2  = 32'(w_head.operand2) > 32'(RF_ENTRIES - 1);
  assign w_op1   = w_bad1 ? '0 : w_head.operand1;
  assign w_op2   = w_bad2 ? '0 : w_head.operand2;
  assign w_clamp = w_bad1 | w_bad2;
`else
  assign w_op1   = w_head.operand1;
  assign w_op2   = w_head.operand2;
  assign w_clamp = 1'b0;
`endif

  // NOTE: storage is deliberately left unreset; r_count and the pointers decide
  // which slots hold live entries, so a flush never has to touch the array.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= '{op:       in_if.in_op,
                           operand1: in_if.in_operand1,
                           operand2: in_if.in_operand2};
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register sees
  // the pre-edge values of w_push/w_pop regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_out_op       <= OP_BUBBLE;
      r_out_operand1 <= '0;
      r_out_operand2 <= '0;
      r_out_issue    <= 1'b0;
      r_out_is_load  <= 1'b0;
      r_issued_cnt   <= '0;
      r_clamp_err    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      if (w_pop) begin
        r_out_op       <= w_head.op;
        r_out_operand1 <= w_op1;
        r_out_operand2 <= w_op2;
        r_out_issue    <= 1'b1;
        r_out_is_load  <= (w_head.op == OP_LOAD);
        r_clamp_err    <= w_clamp;
        if (r_issued_cnt != 8'hFF) r_issued_cnt <= r_issued_cnt + 1'b1;
      end else begin
        r_out_op       <= OP_BUBBLE;
        r_out_operand1 <= '0;
        r_out_operand2 <= '0;
        r_out_issue    <= 1'b0;
        r_out_is_load  <= 1'b0;
        r_clamp_err    <= 1'b0;
      end
    end
  end

  assign out_op       = r_out_op;
  assign out_operand1 = r_out_operand1;
  assign out_operand2 = r_out_operand2;
  assign out_issue    = r_out_issue;
  assign out_is_load  = r_out_is_load;
  assign count        = r_count;
  assign issued_cnt   = r_issued_cnt;
  assign clamp_err    = r_clamp_err;
endmodule

// File: tb/tb_vpipe_issue_queue.sv
// Scoreboard bench for vpipe_issue_queue: directed pushes queue their expected
// issue tuples, and a negedge monitor checks every issued instruction in order.
module tb_vpipe_issue_queue;
  logic       clk = 1'b0;
  logic       rst;
  logic       stall;
  logic [1:0] out_op;
  logic [2:0] out_operand1;
  logic [2:0] out_operand2;
  logic       out_issue;
  logic       out_is_load;
  logic [2:0] count;
  logic [7:0] issued_cnt;
  logic       clamp_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] op;
    logic [2:0] a;
    logic [2:0] b;
    logic       clamp;
  } exp_t;

  exp_t exp_q[$];

  vpipe_issue_if #(.OPW(2), .RW(3)) bus ();

  vpipe_issue_queue #(.DEPTH(4), .RF_ENTRIES(6), .OPW(2), .RW(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_if        (bus),
    .stall        (stall),
    .out_op       (out_op),
    .out_operand1 (out_operand1),
    .out_operand2 (out_operand2),
    .out_issue    (out_issue),
    .out_is_load  (out_is_load),
    .count        (count),
    .issued_cnt   (issued_cnt),
    .clamp_err    (clamp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one beat on the bus; when the queue is known to accept it, queue the
  // tuple the processor should later receive.
  task automatic drive(input logic [1:0] op, input logic [2:0] a, input logic [2:0] b,
                       input bit expect_it);
    exp_t e;
    bus.in_valid    = 1'b1;
    bus.in_op       = op;
    bus.in_operand1 = a;
    bus.in_operand2 = b;
    if (expect_it) begin
      e.op = op;
`ifdef VPIPE_ISSUE_CLAMP_EN
      e.a     = (a > 3'd5) ? 3'd0 : a;
      e.b     = (b > 3'd5) ? 3'd0 : b;
      e.clamp = (a > 3'd5) || (b > 3'd5);
`else
      e.a     = a;
      e.b     = b;
      e.clamp = 1'b0;
`endif
      exp_q.push_back(e);
    end
  endtask

  // Monitor: every issued instruction must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_issue === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_issue: got op=%0h op1=%0h op2=%0h expected no issue",
                   out_op, out_operand1, out_operand2);
        end else begin
          e = exp_q.pop_front();
          check("issue_op",   32'(out_op),       32'(e.op));
          check("issue_op1",  32'(out_operand1), 32'(e.a));
          check("issue_op2",  32'(out_operand2), 32'(e.b));
          check("issue_load", 32'(out_is_load),  32'(e.op == 2'd2));
          check("issue_clamp", 32'(clamp_err),   32'(e.clamp));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst             = 1'b1;
    stall           = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_op       = 2'd0;
    bus.in_operand1 = 3'd0;
    bus.in_operand2 = 3'd0;
    step();
    step();

    // Reset state
    check("rst_count",    32'(count),       32'd0);
    check("rst_ready",    32'(bus.in_ready), 32'd1);
    check("rst_out_op",   32'(out_op),      32'd3);
    check("rst_op1",      32'(out_operand1), 32'd0);
    check("rst_issue",    32'(out_issue),   32'd0);
    check("rst_is_load",  32'(out_is_load), 32'd0);
    check("rst_issued",   32'(issued_cnt),  32'd0);
    check("rst_clamp",    32'(clamp_err),   32'd0);
    rst = 1'b0;

    // T1: single LOAD, two-edge latency then a bubble
    drive(2'd2, 3'd1, 3'd3, 1'b1);
    step();
    bus.in_valid = 1'b0;
    check("t1_count_after_push", 32'(count), 32'd1);
    check("t1_no_bypass",        32'(out_issue), 32'd0);
    step();
    check("t1_issue",   32'(out_issue),   32'd1);
    check("t1_is_load", 32'(out_is_load), 32'd1);
    check("t1_count",   32'(count),       32'd0);
    step();
    check("t1_bubble_op",    32'(out_op),    32'd3);
    check("t1_bubble_issue", 32'(out_issue), 32'd0);

    // T2: fill under stall, overflow attempt, then drain in order
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(2'(i % 3), 3'(i), 3'(i + 1), 1'b1);
      step();
    end
    check("t2_full_count", 32'(count),        32'd4);
    check("t2_full_ready", 32'(bus.in_ready), 32'd0);
    check("t2_stall_bubble", 32'(out_issue),  32'd0);
    drive(2'd1, 3'd5, 3'd5, 1'b0);
    step();
    check("t2_overflow_ignored", 32'(count), 32'd4);
    bus.in_valid = 1'b0;
    stall        = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      step();
      check("t2_drain_count", 32'(count),     32'(i));
      check("t2_drain_issue", 32'(out_issue), 32'd1);
    end
    step();
    check("t2_idle_issue", 32'(out_issue), 32'd0);

    // T3: full queue, then steady push+pop across pointer wrap
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(2'(i % 3), 3'((i + 2) % 6), 3'((i + 4) % 6), 1'b1);
      step();
    end
    check("t3_full_count", 32'(count), 32'd4);
    bus.in_valid = 1'b0;
    stall        = 1'b0;
    step();
    check("t3_after_pop", 32'(count), 32'd3);
    for (int i = 0; i < 10; i++) begin
      drive(2'((i + 1) % 3), 3'(i % 6), 3'((i + 1) % 6), 1'b1);
      step();
      check("t3_steady_count", 32'(count), 32'd3);
    end
    bus.in_valid = 1'b0;
    for (int i = 2; i >= 0; i--) begin
      step();
      check("t3_drain_count", 32'(count), 32'(i));
    end
    step();

    // T4: reset mid-stream discards queued entries
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(2'd0, 3'(i), 3'(i), 1'b0);
      step();
    end
    bus.in_valid = 1'b0;
    check("t4_pre_count", 32'(count), 32'd3);
    rst = 1'b1;
    step();
    check("t4_count",  32'(count),      32'd0);
    check("t4_out_op", 32'(out_op),     32'd3);
    check("t4_issue",  32'(out_issue),  32'd0);
    check("t4_issued", 32'(issued_cnt), 32'd0);
    rst   = 1'b0;
    stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t4_no_stale", 32'(out_issue), 32'd0);
    end

    // T5: out-of-range operands (clamped only when the feature is built in)
    drive(2'd0, 3'd7, 3'd6, 1'b1);
    step();
    drive(2'd1, 3'd6, 3'd2, 1'b1);
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    check("t5_clamp_clears", 32'(clamp_err),  32'd0);
    check("t5_issued",       32'(issued_cnt), 32'd2);

    // T6: issued_cnt saturation
    for (int i = 0; i < 250; i++) begin
      drive(2'(i % 3), 3'(i % 6), 3'((i + 3) % 6), 1'b1);
      step();
    end
    bus.in_valid = 1'b0;
    step();
    check("t6_pre_sat", 32'(issued_cnt), 32'd252);
    for (int i = 0; i < 50; i++) begin
      drive(2'(i % 3), 3'(i % 6), 3'((i + 1) % 6), 1'b1);
      step();
    end
    bus.in_valid = 1'b0;
    step();
    check("t6_saturated", 32'(issued_cnt), 32'd255);
    step();
    step();
    check("t6_holds", 32'(issued_cnt), 32'd255);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
